output_drain_buffer: RTL

//  Receive side of the systolic array result path. Captures the per-column results

---
 rtl/output_drain_buffer_if.sv | 28 ++
 rtl/output_drain_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/output_drain_buffer_if.sv
// Result-path bus: per-column capture inputs from the array and the serialized
// valid/ready output stream. "master" is the drain buffer side.
interface output_drain_buffer_if #(
    parameter int width = 16,
    parameter int cols  = 4
);
    logic [cols-1:0]       cap_en;
    logic [cols*width-1:0] col_in;
    logic [width-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  cap_en,
        input  col_in,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output cap_en,
        output col_in,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/output_drain_buffer.sv
// Captures one rows-deep tile per array column, then streams the whole tile out
// column-major over a single valid/ready port.
module output_drain_buffer #(
    parameter int width = 16,
    parameter int rows  = 4,
    parameter int cols  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output_drain_buffer_if.master bus
);

    localparam int WCW = $clog2(rows + 1);
    localparam int RW  = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW  = (cols > 1) ? $clog2(cols) : 1;
    localparam logic [WCW-1:0] ROWS_CNT = WCW'(rows);
    localparam logic [RW-1:0]  RR_LAST  = RW'(rows - 1);
    localparam logic [CW-1:0]  RC_LAST  = CW'(cols - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wc_q   [cols];
    logic [WCW-1:0]   wc_d   [cols];
    logic [width-1:0] tile_q [cols][rows];
    logic [width-1:0] tile_d [cols][rows];
    logic [RW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    rc_q, rc_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             all_full;

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        tile_d     = tile_q;
        rr_d       = rr_q;
        rc_d       = rc_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        all_full   = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    for (int c = 0; c < cols; c++) begin
                        wc_d[c] = '0;
                    end
                end
            end

            FILL: begin
                // Each column advances on its own strobe, absorbing the array's skew.
                for (int c = 0; c < cols; c++) begin
                    if (bus.cap_en[c]) begin
                        if (wc_q[c] < ROWS_CNT) begin
                            tile_d[c][wc_q[c][RW-1:0]] = bus.col_in[c*width +: width];
                            wc_d[c] = wc_q[c] + WCW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                for (int c = 0; c < cols; c++) begin
                    if (wc_d[c] != ROWS_CNT) begin
                        all_full = 1'b0;
                    end
                end
                if (all_full) begin
                    state_d = DRAIN;
                    rr_d    = '0;
                    rc_d    = '0;
                end
            end

            DRAIN: begin
                if (bus.out_ready) begin
                    if (rr_q == RR_LAST) begin
                        rr_d = '0;
                        if (rc_q == RC_LAST) begin
                            rc_d    = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rc_d = rc_q + CW'(1);
                        end
                    end else begin
                        rr_d = rr_q + RW'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wc_q       <= '{default: '0};
            tile_q     <= '{default: '{default: '0}};
            rr_q       <= '0;
            rc_q       <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            tile_q     <= tile_d;
            rr_q       <= rr_d;
            rc_q       <= rc_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Output word is forced to zero whenever the tile is not being drained.
    always_comb begin
        bus.out_valid = (state_q == DRAIN);
        bus.out_data  = (state_q == DRAIN) ? tile_q[rc_q][rr_q] : '0;
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
